regfile_write_arbiter: RTL and testbench
========================================

Name: regfile_write_arbiter

Overview:
Owns the single write port (WE3/A3/WD3) of the register file. After reset it runs a clear sweep that writes INIT_VALUE to every register. It then shares the write port between the pipeline writeback stage and a debug/loader write requester, using a valid/ready handshake. A starvation counter forces a one-cycle pipeline stall so that debug writes always complete.

Parameters:
NUM_REGS, 32, number of architectural registers; sweep length
ADDR_W, 5, register address width (clog2 of NUM_REGS)
DATA_W, 32, register data width
STARVE_LIMIT, 4, cycles a debug request may wait before a forced slot (minimum 1)
INIT_VALUE, 0, value written to every register during the clear sweep

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  asynchronous, active-high reset
wb_we  in  1  writeback stage write enable
wb_rd  in  ADDR_W  writeback destination register
wb_data  in  DATA_W  writeback data
dbg_valid  in  1  debug write request; held with addr/data stable until accepted
dbg_addr  in  ADDR_W  debug destination register
dbg_data  in  DATA_W  debug write data
dbg_ready  out  1  debug request accepted this cycle (combinational)
stall_req  out  1  freeze pipeline; registered
init_done  out  1  clear sweep complete; registered
rf_we  out  1  to register file WE3
rf_a3  out  ADDR_W  to register file A3
rf_wd3  out  DATA_W  to register file WD3

Behaviour:
- Datapath: rf_we/rf_a3/rf_wd3 are a combinational mux of the current state and inputs. The register file samples them on negedge, so a write lands in the same cycle it is granted. There is zero added latency on the writeback path.
- Reset (async, any time, including mid-sweep): state=INIT, sweep_cnt=0, wait_cnt=0, force=0, init_done=0, stall_req=1. During reset, dbg_ready=0, rf_we=1, rf_a3=0, rf_wd3=INIT_VALUE.
- State INIT:
  - rf_we=1, rf_a3=sweep_cnt, rf_wd3=INIT_VALUE.
  - sweep_cnt increments each posedge.
  - After the cycle with sweep_cnt==NUM_REGS-1, go to RUN: init_done=1, stall_req=0.
  - Sweep lasts exactly NUM_REGS cycles. wb_* and dbg_* are ignored; dbg_ready=0. x0 is written in this state only.
- State RUN, grant priority each cycle:
  1. force==1: debug slot.
  2. wb_we==1 and wb_rd!=0: writeback slot.
  3. dbg_valid==1: debug slot.
  4. Otherwise idle, rf_we=0.
- Writeback slot: rf_we=1, rf_a3=wb_rd, rf_wd3=wb_data. wb_we with wb_rd==0 does not occupy the port and produces no write.
- Debug slot:
  - dbg_ready=dbg_valid; handshake completes when both are high.
  - rf_we=dbg_valid and (dbg_addr!=0), rf_a3=dbg_addr, rf_wd3=dbg_data.
  - A debug write to x0 is accepted and discarded.
- Starvation:
  - wait_cnt increments on each posedge with dbg_valid=1 and dbg_ready=0.
  - When that condition holds with wait_cnt==STARVE_LIMIT-1, set force=1 and stall_req=1 for the next cycle.
  - In the forced cycle, debug is granted even though wb_we=1. The pipeline holds its WB stage under stall_req, so the writeback repeats next cycle and is not lost.
  - On the following posedge, force, stall_req and wait_cnt clear.
  - wait_cnt also clears on any debug acceptance.
  - stall_req is high for exactly one cycle per forced slot (outside INIT).
- Debug request withdrawn (dbg_valid=0) while force==1: the forced cycle still asserts stall_req, but rf_we=0 and no write occurs; force and wait_cnt then clear. Withdrawal is a protocol violation; the arbiter tolerates it.
- Back-to-back debug requests with wb_we continuously set: one forced slot every STARVE_LIMIT+1 cycles.
- The arbiter never issues two writes in one cycle, and rf_we is never high with rf_a3==0 outside INIT.

Decomposition:
- Shared package regfile_pkg:
  - ADDR_W, DATA_W and NUM_REGS constants.
  - State encoding ARB_INIT=1'b0, ARB_RUN=1'b1.
  - Slot-select encoding SEL_IDLE, SEL_WB, SEL_DBG, SEL_SWEEP (2 bits).
- One natural sub-module, regfile_starve_ctr: wait_cnt plus force/stall_req generation, with inputs dbg_valid and dbg_ready and output force. The grant mux stays in the top module.

Test Plan:
- Reset sweep: pulse rst, then release. Required: rf_we=1 with rf_a3 stepping 0..31 and rf_wd3=0 over 32 cycles, stall_req=1 throughout, then init_done=1 and stall_req=0 in cycle 33.
- Reset mid-sweep: assert rst while rf_a3=17. Required: outputs immediately return to rf_a3=0, and the sweep restarts for a full 32 cycles.
- Priority: wb_we=1, wb_rd=5, wb_data=0xAA together with dbg_valid=1, dbg_addr=6. Required: write 0xAA to r5 and dbg_ready=0. On the next cycle with wb_we=0, write dbg_data to r6 and dbg_ready=1.
- x0 filtering: wb_we=1, wb_rd=0 with dbg_valid=1, dbg_addr=3, dbg_data=0x55. Required: debug granted, r3=0x55, no x0 write. Then dbg_addr=0. Required: dbg_ready=1, rf_we=0.
- Starvation with STARVE_LIMIT=4: wb_we=1 to r7 every cycle and dbg_valid=1 from cycle 0. Required: dbg_ready=0 for cycles 0-3, then stall_req=1 and debug write in cycle 4, stall_req=0 in cycle 5, and the r7 writeback resumes.
- Withdrawn request: dbg_valid drops in the forced cycle. Required: stall_req=1 for that one cycle, rf_we=0, and wait_cnt=0 afterwards.

Source files
------------

// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared constants and encodings for the register-file write arbiter.
//   NUM_REGS / ADDR_W / DATA_W : default register-file geometry
//   arb_state_e                : arbiter phase (clear sweep, normal run)
//   slot_sel_e                 : which requester owns the write port this cycle
// -----------------------------------------------------------------------------
package regfile_pkg;

   localparam int NUM_REGS = 32;
   localparam int ADDR_W   = 5;
   localparam int DATA_W   = 32;

   typedef enum logic {
      ARB_INIT = 1'b0,
      ARB_RUN  = 1'b1
   } arb_state_e;

   typedef enum logic [1:0] {
      SEL_IDLE  = 2'd0,
      SEL_WB    = 2'd1,
      SEL_DBG   = 2'd2,
      SEL_SWEEP = 2'd3
   } slot_sel_e;

endpackage

// File: rtl/regfile_starve_ctr.sv
// -----------------------------------------------------------------------------
// regfile_starve_ctr
// Counts how long a debug write request has been refused and, once it has
// waited STARVE_LIMIT cycles, forces one debug slot and stalls the pipeline
// for that single cycle. Also owns the registered stall request, which is held
// high through the clear sweep.
// Ports:
//   clk, rst       : clock, asynchronous active-high reset
//   run_i          : arbiter is in its normal run phase (counting enabled)
//   hold_stall_i   : keep the stall request high next cycle (sweep not done)
//   dbg_valid_i    : debug request pending
//   dbg_ready_i    : debug request accepted this cycle
//   force_o        : this cycle is a forced debug slot
//   stall_req_o    : registered pipeline stall request
//   wait_cnt_o     : current refusal count (observability)
// -----------------------------------------------------------------------------
module regfile_starve_ctr #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic run_i,
   input  logic hold_stall_i,
   input  logic dbg_valid_i,
   input  logic dbg_ready_i,
   output logic force_o,
   output logic stall_req_o,
   output logic [((STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1)-1:0] wait_cnt_o
);

   // The counter only ever needs to reach STARVE_LIMIT-1.
   localparam int CW = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;
   localparam logic [CW-1:0] LIM_M1 = CW'(STARVE_LIMIT - 1);

   logic [CW-1:0] wait_cnt_q, wait_cnt_d;
   logic          force_q, force_d;
   logic          stall_q, stall_d;

   always_comb begin : next_state
      wait_cnt_d = wait_cnt_q;
      force_d    = 1'b0;
      if (!run_i) begin
         wait_cnt_d = '0;
      end else if (force_q) begin
         // The forced slot has been spent (or withdrawn); start over.
         wait_cnt_d = '0;
      end else if (dbg_valid_i && dbg_ready_i) begin
         wait_cnt_d = '0;
      end else if (dbg_valid_i) begin
         if (wait_cnt_q == LIM_M1) begin
            force_d = 1'b1;
         end else begin
            wait_cnt_d = wait_cnt_q + CW'(1);
         end
      end
      stall_d = hold_stall_i | force_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wait_cnt_q <= '0;
         force_q    <= 1'b0;
         stall_q    <= 1'b1;
      end else begin
         wait_cnt_q <= wait_cnt_d;
         force_q    <= force_d;
         stall_q    <= stall_d;
      end
   end

   assign force_o     = force_q;
   assign stall_req_o = stall_q;
   assign wait_cnt_o  = wait_cnt_q;

endmodule

// File: rtl/regfile_write_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_write_arbiter
// Owns the register file's single write port (WE3/A3/WD3). After reset it
// sweeps INIT_VALUE into every register, then shares the port between the
// writeback stage (priority) and a debug/loader requester (valid/ready).
// Handshake: dbg_valid is raised with dbg_addr/dbg_data stable and held until
// dbg_ready is seen high in the same cycle; the transfer happens in that cycle.
// A starved debug request gets one forced slot, with stall_req freezing the
// pipeline so the displaced writeback repeats next cycle.
// Ports:
//   clk, rst                      : clock, asynchronous active-high reset
//   wb_we, wb_rd, wb_data         : writeback write request (no handshake)
//   dbg_valid, dbg_addr, dbg_data : debug write request
//   dbg_ready                     : debug request accepted (combinational)
//   stall_req                     : registered pipeline freeze
//   init_done                     : registered, clear sweep finished
//   rf_we, rf_a3, rf_wd3          : to register file write port (combinational)
// -----------------------------------------------------------------------------
module regfile_write_arbiter
   import regfile_pkg::*;
#(
   parameter int                NUM_REGS     = regfile_pkg::NUM_REGS,
   parameter int                ADDR_W       = regfile_pkg::ADDR_W,
   parameter int                DATA_W       = regfile_pkg::DATA_W,
   parameter int                STARVE_LIMIT = 4,
   parameter logic [DATA_W-1:0] INIT_VALUE   = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wb_we,
   input  logic [ADDR_W-1:0] wb_rd,
   input  logic [DATA_W-1:0] wb_data,
   input  logic              dbg_valid,
   input  logic [ADDR_W-1:0] dbg_addr,
   input  logic [DATA_W-1:0] dbg_data,
   output logic              dbg_ready,
   output logic              stall_req,
   output logic              init_done,
   output logic              rf_we,
   output logic [ADDR_W-1:0] rf_a3,
   output logic [DATA_W-1:0] rf_wd3
);

   localparam logic [ADDR_W-1:0] LAST_REG = ADDR_W'(NUM_REGS - 1);
   localparam int CW = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;

   arb_state_e        state_q, state_d;
   logic [ADDR_W-1:0] sweep_cnt_q, sweep_cnt_d;
   logic              init_done_q, init_done_d;
   slot_sel_e         sel;
   logic              force_slot;
   logic              hold_stall;
   logic              sweep_last;
   logic [CW-1:0]     wait_cnt;

   assign sweep_last = (sweep_cnt_q == LAST_REG);

   // ---------------- phase FSM ----------------
   always_comb begin : fsm_next
      state_d     = state_q;
      sweep_cnt_d = sweep_cnt_q;
      init_done_d = init_done_q;
      hold_stall  = 1'b0;
      if (state_q == ARB_INIT) begin
         if (sweep_last) begin
            state_d     = ARB_RUN;
            init_done_d = 1'b1;
            sweep_cnt_d = '0;
         end else begin
            sweep_cnt_d = sweep_cnt_q + ADDR_W'(1);
            hold_stall  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ARB_INIT;
         sweep_cnt_q <= '0;
         init_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         sweep_cnt_q <= sweep_cnt_d;
         init_done_q <= init_done_d;
      end
   end

   // ---------------- starvation control ----------------
   regfile_starve_ctr #(
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_starve (
      .clk          (clk),
      .rst          (rst),
      .run_i        (state_q == ARB_RUN),
      .hold_stall_i (hold_stall),
      .dbg_valid_i  (dbg_valid),
      .dbg_ready_i  (dbg_ready),
      .force_o      (force_slot),
      .stall_req_o  (stall_req),
      .wait_cnt_o   (wait_cnt)
   );

   // ---------------- grant ----------------
   // A writeback to x0 is not a real write, so it never blocks debug.
   always_comb begin : grant
      sel = SEL_IDLE;
      if (state_q == ARB_INIT) begin
         sel = SEL_SWEEP;
      end else if (force_slot) begin
         sel = SEL_DBG;
      end else if (wb_we && (wb_rd != '0)) begin
         sel = SEL_WB;
      end else if (dbg_valid) begin
         sel = SEL_DBG;
      end
   end

   always_comb begin : port_mux
      rf_we     = 1'b0;
      rf_a3     = '0;
      rf_wd3    = '0;
      dbg_ready = 1'b0;
      case (sel)
         SEL_SWEEP: begin
            rf_we  = 1'b1;
            rf_a3  = sweep_cnt_q;
            rf_wd3 = INIT_VALUE;
         end
         SEL_WB: begin
            rf_we  = 1'b1;
            rf_a3  = wb_rd;
            rf_wd3 = wb_data;
         end
         SEL_DBG: begin
            // A debug write to x0 is accepted but never reaches the port.
            dbg_ready = dbg_valid;
            rf_we     = dbg_valid && (dbg_addr != '0);
            rf_a3     = dbg_addr;
            rf_wd3    = dbg_data;
         end
         default: begin
         end
      endcase
   end

   assign init_done = init_done_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_write_arbiter
// Bench for regfile_write_arbiter: per-cycle expected port behaviour is derived
// from a cycle-count / refusal-count model and queued; a negedge monitor pops
// and compares.
// -----------------------------------------------------------------------------
module tb_regfile_write_arbiter;

   localparam int NUM_REGS     = 32;
   localparam int ADDR_W       = 5;
   localparam int DATA_W       = 32;
   localparam int STARVE_LIMIT = 4;
   localparam logic [DATA_W-1:0] INIT_VALUE = '0;
   localparam int EW = 1 + ADDR_W + DATA_W + 3;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic              wb_we = 1'b0;
   logic [ADDR_W-1:0] wb_rd = '0;
   logic [DATA_W-1:0] wb_data = '0;
   logic              dbg_valid = 1'b0;
   logic [ADDR_W-1:0] dbg_addr = '0;
   logic [DATA_W-1:0] dbg_data = '0;
   logic              dbg_ready, stall_req, init_done, rf_we;
   logic [ADDR_W-1:0] rf_a3;
   logic [DATA_W-1:0] rf_wd3;

   regfile_write_arbiter #(
      .NUM_REGS     (NUM_REGS),
      .ADDR_W       (ADDR_W),
      .DATA_W       (DATA_W),
      .STARVE_LIMIT (STARVE_LIMIT),
      .INIT_VALUE   (INIT_VALUE)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .wb_we     (wb_we),
      .wb_rd     (wb_rd),
      .wb_data   (wb_data),
      .dbg_valid (dbg_valid),
      .dbg_addr  (dbg_addr),
      .dbg_data  (dbg_data),
      .dbg_ready (dbg_ready),
      .stall_req (stall_req),
      .init_done (init_done),
      .rf_we     (rf_we),
      .rf_a3     (rf_a3),
      .rf_wd3    (rf_wd3)
   );

   // ---------------- scoreboard state ----------------
   logic [EW-1:0] exp_q[$];
   string         name_q[$];
   int            total = 0;
   int            bad   = 0;

   // ---------------- reference model ----------------
   // m_t      : cycles since reset (sweep while below NUM_REGS)
   // m_refused: consecutive cycles the pending debug request was turned away
   // m_force  : this cycle belongs to the starved debug request
   int m_t       = 0;
   int m_refused = 0;
   bit m_force   = 1'b0;
   bit l_dv      = 1'b0;
   bit l_ready   = 1'b0;

   function automatic void model_reset();
      m_t       = 0;
      m_refused = 0;
      m_force   = 1'b0;
      l_dv      = 1'b0;
      l_ready   = 1'b0;
   endfunction

   function automatic void model_advance();
      if (m_t < NUM_REGS) begin
         m_t++;
      end else if (m_force) begin
         m_force   = 1'b0;
         m_refused = 0;
      end else if (l_dv && !l_ready) begin
         m_refused++;
         if (m_refused == STARVE_LIMIT) m_force = 1'b1;
      end else if (l_dv && l_ready) begin
         m_refused = 0;
      end
   endfunction

   function automatic logic [EW-1:0] model_expect(
      input logic we, input logic [ADDR_W-1:0] rd, input logic [DATA_W-1:0] wd,
      input logic dv, input logic [ADDR_W-1:0] da, input logic [DATA_W-1:0] dd);
      logic              e_we, e_rdy, e_stall, e_done;
      logic [ADDR_W-1:0] e_a3;
      logic [DATA_W-1:0] e_wd;
      e_we = 1'b0; e_rdy = 1'b0; e_a3 = '0; e_wd = '0;
      if (m_t < NUM_REGS) begin
         e_we    = 1'b1;
         e_a3    = ADDR_W'(m_t);
         e_wd    = INIT_VALUE;
         e_stall = 1'b1;
         e_done  = 1'b0;
      end else begin
         e_done  = 1'b1;
         e_stall = m_force;
         if (!m_force && we && rd != '0) begin
            e_we = 1'b1; e_a3 = rd; e_wd = wd;
         end else if (dv) begin
            e_rdy = 1'b1;
            if (da != '0) begin
               e_we = 1'b1; e_a3 = da; e_wd = dd;
            end
         end
      end
      l_dv    = dv && (m_t >= NUM_REGS);
      l_ready = e_rdy;
      return {e_we, e_a3, e_wd, e_rdy, e_stall, e_done};
   endfunction

   // ---------------- driver tasks ----------------
   task automatic drive_cycle(input string nm,
      input logic we, input logic [ADDR_W-1:0] rd, input logic [DATA_W-1:0] wd,
      input logic dv, input logic [ADDR_W-1:0] da, input logic [DATA_W-1:0] dd);
      @(posedge clk);
      model_advance();
      #1;
      wb_we = we; wb_rd = rd; wb_data = wd;
      dbg_valid = dv; dbg_addr = da; dbg_data = dd;
      exp_q.push_back(model_expect(we, rd, wd, dv, da, dd));
      name_q.push_back(nm);
   endtask

   task automatic idle_cycle(input string nm);
      drive_cycle(nm, 1'b0, '0, '0, 1'b0, '0, '0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      total++;
      if (rf_we !== 1'b1 || rf_a3 !== '0 || rf_wd3 !== INIT_VALUE ||
          dbg_ready !== 1'b0 || stall_req !== 1'b1 || init_done !== 1'b0) begin
         bad++;
         $display("FAIL rst_async: got we=%0b a3=%0d wd=%h rdy=%0b stall=%0b done=%0b, want we=1 a3=0 wd=%h rdy=0 stall=1 done=0",
                  rf_we, rf_a3, rf_wd3, dbg_ready, stall_req, init_done, INIT_VALUE);
      end
      exp_q.push_back(model_expect(wb_we, wb_rd, wb_data, dbg_valid, dbg_addr, dbg_data));
      name_q.push_back("rst_hold");
      @(negedge clk);
      #2;
      rst = 1'b0;
   endtask

   task automatic sweep_cycles(input string nm, input int n);
      for (int i = 0; i < n; i++) begin
         drive_cycle(nm, 1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, NUM_REGS - 1)),
                     DATA_W'($urandom), 1'($urandom_range(0, 1)),
                     ADDR_W'($urandom_range(0, NUM_REGS - 1)), DATA_W'($urandom));
      end
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      logic [EW-1:0] e;
      string         nm;
      logic          ok;
      if (exp_q.size() > 0) begin
         e  = exp_q.pop_front();
         nm = name_q.pop_front();
         ok = (rf_we === e[EW-1]) && (dbg_ready === e[2]) &&
              (stall_req === e[1]) && (init_done === e[0]);
         if (e[EW-1] && (rf_a3 !== e[EW-2 -: ADDR_W] || rf_wd3 !== e[DATA_W+2:3])) ok = 1'b0;
         total++;
         if (!ok) begin
            bad++;
            $display("FAIL %s @%0t: got we=%0b a3=%0d wd=%h rdy=%0b stall=%0b done=%0b, want we=%0b a3=%0d wd=%h rdy=%0b stall=%0b done=%0b",
                     nm, $time, rf_we, rf_a3, rf_wd3, dbg_ready, stall_req, init_done,
                     e[EW-1], e[EW-2 -: ADDR_W], e[DATA_W+2:3], e[2], e[1], e[0]);
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      logic              r_dv;
      logic [ADDR_W-1:0] r_da;
      logic [DATA_W-1:0] r_dd;

      // Reset sweep with junk on the request inputs, which must be ignored.
      do_reset();
      sweep_cycles("sweep", NUM_REGS - 1);
      idle_cycle("run_first");

      // Reset in the middle of a sweep, then a full sweep again.
      do_reset();
      sweep_cycles("sweep_pre", 17);
      do_reset();
      sweep_cycles("sweep_restart", NUM_REGS - 1);
      idle_cycle("run_after_restart");

      // Writeback beats debug; debug goes when writeback is quiet.
      drive_cycle("prio_wb",  1'b1, 5'd5, 32'hAA, 1'b1, 5'd6, 32'h1234_5678);
      drive_cycle("prio_dbg", 1'b0, 5'd0, 32'h0,  1'b1, 5'd6, 32'h1234_5678);

      // x0 filtering on both requesters.
      drive_cycle("x0_wb_ignored", 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd3, 32'h55);
      drive_cycle("x0_dbg_drop",   1'b0, 5'd0, 32'h0,         1'b1, 5'd0, 32'h77);
      idle_cycle("idle");

      // Starvation: forced slot after STARVE_LIMIT refusals, then writeback resumes.
      for (int i = 0; i < STARVE_LIMIT; i++)
         drive_cycle("starve_wait", 1'b1, 5'd7, DATA_W'(100 + i), 1'b1, 5'd9, 32'hBEEF);
      drive_cycle("starve_force",  1'b1, 5'd7, 32'd104, 1'b1, 5'd9, 32'hBEEF);
      drive_cycle("starve_resume", 1'b1, 5'd7, 32'd104, 1'b0, 5'd0, 32'h0);
      idle_cycle("idle");

      // Withdrawn request in the forced cycle; the count restarts from zero.
      for (int i = 0; i < STARVE_LIMIT; i++)
         drive_cycle("wd_wait", 1'b1, 5'd7, DATA_W'(200 + i), 1'b1, 5'd10, 32'hCAFE);
      drive_cycle("wd_force_empty", 1'b1, 5'd7, 32'd204, 1'b0, 5'd10, 32'hCAFE);
      for (int i = 0; i < STARVE_LIMIT; i++)
         drive_cycle("wd_rewait", 1'b1, 5'd7, DATA_W'(205 + i), 1'b1, 5'd11, 32'hF00D);
      drive_cycle("wd_reforce", 1'b1, 5'd7, 32'd209, 1'b1, 5'd11, 32'hF00D);

      // Back-to-back debug requests against continuous writeback.
      r_dv = 1'b0; r_da = '0; r_dd = '0;
      for (int i = 0; i < 3 * (STARVE_LIMIT + 1); i++) begin
         if (!r_dv) begin
            r_dv = 1'b1;
            r_da = ADDR_W'($urandom_range(1, NUM_REGS - 1));
            r_dd = DATA_W'($urandom);
         end
         drive_cycle("b2b", 1'b1, 5'd8, DATA_W'($urandom), r_dv, r_da, r_dd);
         if (l_ready) r_dv = 1'b0;
      end
      idle_cycle("idle");

      // Random traffic respecting the debug hold-until-accepted rule.
      r_dv = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (!r_dv && $urandom_range(0, 99) < 40) begin
            r_dv = 1'b1;
            r_da = ADDR_W'($urandom_range(0, NUM_REGS - 1));
            r_dd = DATA_W'($urandom);
         end
         drive_cycle("random", 1'($urandom_range(0, 99) < 70),
                     ADDR_W'($urandom_range(0, NUM_REGS - 1)), DATA_W'($urandom),
                     r_dv, r_da, r_dd);
         if (l_ready) r_dv = 1'b0;
      end

      @(negedge clk);
      #1;
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain: got %0d unchecked entries, want 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // ---------------- watchdog ----------------
   initial begin
      #200000;
      bad++;
      $display("FAIL watchdog: got timeout at %0t, want completion", $time);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
